// File: rtl/shifter_pipe.sv
// shifter_pipe: two-stage pipelined ARM shifter-operand unit (LSL/LSR/ASR/ROR/RRX)
// with valid/ready flow control. Stage 1 decodes and clamps the amount, stage 2
// performs the shift and registers result, carry, zero and tag.
module shifter_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_operand,
  input  logic [7:0]       in_amount,
  input  logic [1:0]       in_type,
  input  logic             in_reg,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned LW = $clog2(WIDTH);
  // Decoded amount holds 0..N+1, so one bit more than LW is enough.
  localparam int unsigned AW = LW + 1;
  localparam logic [AW-1:0] N_A  = AW'(WIDTH);
  localparam logic [AW-1:0] N1_A = AW'(WIDTH + 1);

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  logic v1, v2, adv1, adv2;

  // Stage 1 registers
  shift_t           s1_type;
  logic             s1_rrx;
  logic [AW-1:0]    s1_amt;
  logic [WIDTH-1:0] s1_op;
  logic             s1_cin;
  logic [TAG_W-1:0] s1_tag;

  shift_t           dec_type;
  logic             dec_rrx;
  logic [AW-1:0]    dec_amt;

  logic [WIDTH-1:0] sh_res;
  logic             sh_carry;
  logic [LW-1:0]    idx_hi, idx_lo;

  // Flow control: a stage advances when empty or when the stage after it advances.
  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;

  // Decode: immediate #0 remaps, overrange clamp to N+1, ROR reduced mod N.
  // A register ROR by a nonzero multiple of N is encoded as amount N.
  always_comb begin
    dec_type = shift_t'(in_type);
    dec_rrx  = 1'b0;
    dec_amt  = '0;
    if (!in_reg) begin
      dec_amt = AW'(in_amount[LW-1:0]);
      if (in_amount[LW-1:0] == '0) begin
        case (dec_type)
          SH_LSR, SH_ASR: dec_amt = N_A;
          SH_ROR:         dec_rrx = 1'b1;
          default:        dec_amt = '0;
        endcase
      end
    end else if (dec_type == SH_ROR) begin
      if (in_amount[LW-1:0] != '0) begin
        dec_amt = AW'(in_amount[LW-1:0]);
      end else if (in_amount != 8'd0) begin
        dec_amt = N_A;
      end
    end else if (in_amount >= 8'(WIDTH + 1)) begin
      dec_amt = N1_A;
    end else begin
      dec_amt = AW'(in_amount);
    end
  end

  // Stage 1 register: capture decoded beat on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      s1_type <= SH_LSL;
      s1_rrx  <= 1'b0;
      s1_amt  <= '0;
      s1_op   <= '0;
      s1_cin  <= 1'b0;
      s1_tag  <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_type <= dec_type;
        s1_rrx  <= dec_rrx;
        s1_amt  <= dec_amt;
        s1_op   <= in_operand;
        s1_cin  <= in_cin;
        s1_tag  <= in_tag;
      end
    end
  end

  // Bit indices for carry-out; only consulted when 1 <= amount <= N-1.
  assign idx_hi = LW'(N_A - s1_amt);
  assign idx_lo = LW'(s1_amt - AW'(1));

  // Shift datapath and carry-out selection.
  always_comb begin
    sh_res   = s1_op;
    sh_carry = s1_cin;
    if (s1_rrx) begin
      sh_res   = {s1_cin, s1_op[WIDTH-1:1]};
      sh_carry = s1_op[0];
    end else if (s1_amt != '0) begin
      case (s1_type)
        SH_LSL: begin
          if (s1_amt < N_A) begin
            sh_res   = s1_op << s1_amt;
            sh_carry = s1_op[idx_hi];
          end else begin
            sh_res   = '0;
            sh_carry = (s1_amt == N_A) ? s1_op[0] : 1'b0;
          end
        end
        SH_LSR: begin
          if (s1_amt < N_A) begin
            sh_res   = s1_op >> s1_amt;
            sh_carry = s1_op[idx_lo];
          end else begin
            sh_res   = '0;
            sh_carry = (s1_amt == N_A) ? s1_op[WIDTH-1] : 1'b0;
          end
        end
        SH_ASR: begin
          if (s1_amt < N_A) begin
            sh_res   = WIDTH'($signed(s1_op) >>> s1_amt);
            sh_carry = s1_op[idx_lo];
          end else begin
            sh_res   = {WIDTH{s1_op[WIDTH-1]}};
            sh_carry = s1_op[WIDTH-1];
          end
        end
        default: begin
          if (s1_amt == N_A) begin
            sh_carry = s1_op[WIDTH-1];
          end else begin
            sh_res   = (s1_op >> s1_amt) | (s1_op << (N_A - s1_amt));
            sh_carry = s1_op[idx_lo];
          end
        end
      endcase
    end
  end

  // Stage 2 register: output stage, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2        <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        out_data  <= sh_res;
        out_carry <= sh_carry;
        out_zero  <= (sh_res == '0);
        out_tag   <= s1_tag;
      end
    end
  end

endmodule
